// File: rtl/mem_stage_ctrl_pkg.sv
// Shared constants and types for the MEM stage: default widths, the
// data-memory FSM states and the MEM/WB bundle.
package mem_stage_ctrl_pkg;

  localparam int XLEN    = 64;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      rd;
    logic            reg_write;
    logic            memToReg;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_ctrl_mem_wb.sv
// MEM/WB pipeline register. A bubble kills the control bits but keeps the data,
// the same way the EX/MEM register treats a flush.
module mem_wb_register
  import mem_stage_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    bubble_i,
  input  logic    load_done_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);

  mem_wb_t wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      if (bubble_i) begin
        wb_q.reg_write <= 1'b0;
        wb_q.memToReg  <= 1'b0;
      end else begin
        wb_q.alu_result <= d_i.alu_result;
        wb_q.rd         <= d_i.rd;
        wb_q.reg_write  <= d_i.reg_write;
        wb_q.memToReg   <= d_i.memToReg;
      end
      // Load data is only trustworthy in the cycle memory signals ready.
      if (load_done_i) begin
        wb_q.read_data <= d_i.read_data;
      end
    end
  end

  assign q_o = wb_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: data-memory handshake with timeout, branch resolution
// against the carried prediction, predictor update, counters and MEM/WB register.
module mem_stage_ctrl #(
  parameter int XLEN        = mem_stage_ctrl_pkg::XLEN,
  parameter int PC_STEP     = mem_stage_ctrl_pkg::PC_STEP,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_value,
  input  logic [XLEN-1:0]  pc_plus_imm,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  rd2,
  input  logic [4:0]       rd,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             memToReg,
  input  logic             branch,
  input  logic             reg_write,
  input  logic             zero,
  input  logic             prediction,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ready,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             bp_update,
  output logic             bp_taken,
  output logic [XLEN-1:0]  bp_pc,
  output logic             dmem_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [XLEN-1:0]  wb_read_data,
  output logic [XLEN-1:0]  wb_alu_result,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic             wb_memToReg
);

  import mem_stage_ctrl_pkg::*;

  localparam int             WCW         = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             access;
  logic             taken;
  logic             load_done;
  logic             bp_update_q, bp_taken_q;
  logic [XLEN-1:0]  bp_pc_q;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  mem_wb_t          wb_d, wb_q;

  // Gating with rst_n lets stall and the request drop the instant reset asserts.
  assign dmem_err   = (state_q == ERR);
  assign access     = (mem_read | mem_write) & ~dmem_err & rst_n;
  assign dmem_req   = access;
  assign dmem_we    = mem_write;
  assign dmem_addr  = alu_result;
  assign dmem_wdata = rd2;
  assign stall      = access & ~dmem_ready;
  assign load_done  = access & mem_read & ~mem_write & dmem_ready;

  assign taken       = branch & zero;
  assign flush       = branch & (taken ^ prediction) & rst_n;
  assign redirect_pc = taken ? pc_plus_imm : (pc_value + XLEN'(PC_STEP));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (access && !dmem_ready) begin
          state_d    = WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
          if (wait_cnt_d == TIMEOUT_CNT) begin
            state_d = ERR;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (branch && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (flush && !(&mispredict_cnt_q)) begin
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      wait_cnt_q       <= '0;
      bp_update_q      <= 1'b0;
      bp_taken_q       <= 1'b0;
      bp_pc_q          <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      bp_update_q      <= branch;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      if (branch) begin
        bp_taken_q <= taken;
        bp_pc_q    <= pc_value;
      end
    end
  end

  assign bp_update      = bp_update_q;
  assign bp_taken       = bp_taken_q;
  assign bp_pc          = bp_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  assign wb_d = '{read_data:  dmem_rdata,
                  alu_result: alu_result,
                  rd:         rd,
                  reg_write:  reg_write,
                  memToReg:   memToReg};

  mem_wb_register u_mem_wb (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble_i    (stall),
    .load_done_i (load_done),
    .d_i         (wb_d),
    .q_o         (wb_q)
  );

  assign wb_read_data  = wb_q.read_data;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_rd         = wb_q.rd;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_memToReg   = wb_q.memToReg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random instruction stream,
// all checked every cycle against an instruction-level reference model.
module tb_mem_stage_ctrl;

  localparam int CW  = 4;
  localparam int SAT = 15;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc_value, pc_plus_imm, alu_result, rd2, dmem_rdata;
  logic [4:0]  rd;
  logic        mem_read, mem_write, memToReg, branch, reg_write, zero, prediction, dmem_ready;
  logic        dmem_req, dmem_we, stall, flush, bp_update, bp_taken, dmem_err;
  logic        wb_reg_write, wb_memToReg;
  logic [63:0] dmem_addr, dmem_wdata, redirect_pc, bp_pc, wb_read_data, wb_alu_result;
  logic [CW-1:0] branch_cnt, mispredict_cnt;
  logic [4:0]  wb_rd;

  int checks = 0;
  int failures = 0;
  bit done = 0;

  // Reference model state: what the outputs must read during the current cycle.
  bit          m_err;
  int          m_run;
  logic [63:0] m_rdata, m_alu, m_bp_pc;
  logic [4:0]  m_rd;
  bit          m_rw, m_mtr, m_bp_upd, m_bp_taken;
  int          m_bcnt, m_mcnt;

  mem_stage_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_value(pc_value), .pc_plus_imm(pc_plus_imm),
    .alu_result(alu_result), .rd2(rd2), .rd(rd), .mem_read(mem_read),
    .mem_write(mem_write), .memToReg(memToReg), .branch(branch), .reg_write(reg_write),
    .zero(zero), .prediction(prediction), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .bp_update(bp_update), .bp_taken(bp_taken), .bp_pc(bp_pc), .dmem_err(dmem_err),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_memToReg(wb_memToReg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_run = 0; m_rdata = '0; m_alu = '0; m_rd = '0; m_rw = 0; m_mtr = 0;
    m_bp_upd = 0; m_bp_taken = 0; m_bp_pc = '0; m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic nop();
    pc_value = '0; pc_plus_imm = '0; alu_result = '0; rd2 = '0; dmem_rdata = '0; rd = '0;
    mem_read = 0; mem_write = 0; memToReg = 0; branch = 0; reg_write = 0;
    zero = 0; prediction = 0; dmem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: inputs are stable from posedge+1 to the next posedge, so at the
  // negedge the model checks this cycle and then advances across the coming edge.
  initial begin
    bit e_access, e_stall, e_taken, e_flush;
    logic [63:0] e_redir;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && !done) begin
        e_access = (mem_read || mem_write) && !m_err;
        e_stall  = e_access && !dmem_ready;
        e_taken  = branch && zero;
        e_flush  = branch && (e_taken != prediction);
        e_redir  = e_taken ? pc_plus_imm : pc_value + 64'd4;
        chk("stall", {63'd0, stall}, {63'd0, e_stall});
        chk("dmem_req", {63'd0, dmem_req}, {63'd0, e_access});
        chk("dmem_we", {63'd0, dmem_we}, {63'd0, mem_write});
        chk("dmem_addr", dmem_addr, alu_result);
        chk("dmem_wdata", dmem_wdata, rd2);
        chk("flush", {63'd0, flush}, {63'd0, e_flush});
        chk("redirect_pc", redirect_pc, e_redir);
        chk("dmem_err", {63'd0, dmem_err}, {63'd0, m_err});
        chk("bp_update", {63'd0, bp_update}, {63'd0, m_bp_upd});
        chk("bp_taken", {63'd0, bp_taken}, {63'd0, m_bp_taken});
        chk("bp_pc", bp_pc, m_bp_pc);
        chk("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
        chk("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
        chk("wb_read_data", wb_read_data, m_rdata);
        chk("wb_alu_result", wb_alu_result, m_alu);
        chk("wb_rd", 64'(wb_rd), 64'(m_rd));
        chk("wb_reg_write", {63'd0, wb_reg_write}, {63'd0, m_rw});
        chk("wb_memToReg", {63'd0, wb_memToReg}, {63'd0, m_mtr});
        if (e_stall) begin
          m_run++;
          if (m_run == TMO) m_err = 1;
          m_rw = 0; m_mtr = 0;
        end else begin
          m_run = 0;
          m_alu = alu_result; m_rd = rd; m_rw = reg_write; m_mtr = memToReg;
        end
        if (e_access && mem_read && !mem_write && dmem_ready) m_rdata = dmem_rdata;
        m_bp_upd = branch;
        if (branch) begin m_bp_taken = e_taken; m_bp_pc = pc_value; end
        if (branch && m_bcnt < SAT) m_bcnt++;
        if (e_flush && m_mcnt < SAT) m_mcnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbr;
    int kind;
    int w;
    int nstall;
    model_reset();
    nop();
    step(); step();
    #2;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_wb_rw", {63'd0, wb_reg_write}, 64'd0);
    chk("rst_wb_data", wb_read_data, 64'd0);
    chk("rst_bcnt", 64'(branch_cnt), 64'd0);
    chk("rst_err", {63'd0, dmem_err}, 64'd0);
    step();
    rst_n = 1;

    $display("txn load zero-wait addr=0x100");
    mem_read = 1; alu_result = 64'h100; dmem_ready = 1; dmem_rdata = 64'hDEAD;
    memToReg = 1; reg_write = 1; rd = 5'd5;
    #2 chk("zw_stall", {63'd0, stall}, 64'd0);
    step();

    $display("txn load 3-wait addr=0x100");
    nop();
    mem_read = 1; alu_result = 64'h100; memToReg = 1; reg_write = 1; rd = 5'd6;
    dmem_rdata = 64'h1111;
    #2;
    chk("zw_rdata", wb_read_data, 64'hDEAD);
    chk("zw_mtr", {63'd0, wb_memToReg}, 64'd1);
    nstall = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) chk("wait_wb_rw", {63'd0, wb_reg_write}, 64'd0);
      if (stall) nstall++;
      chk("wait_addr", dmem_addr, 64'h100);
      step();
      dmem_rdata = 64'h2222 + 64'(i);
      #2;
    end
    dmem_ready = 1; dmem_rdata = 64'hBEEF;
    #1;
    chk("wait_nstall", 64'(nstall), 64'd3);
    chk("wait_done_stall", {63'd0, stall}, 64'd0);
    chk("wait_done_wb_rw", {63'd0, wb_reg_write}, 64'd0);
    step();

    $display("txn store wdata=0x55");
    nop();
    mem_write = 1; rd2 = 64'h55; alu_result = 64'h200; dmem_ready = 1; reg_write = 0;
    #2;
    chk("ld_rdata", wb_read_data, 64'hBEEF);
    chk("ld_wb_rw", {63'd0, wb_reg_write}, 64'd1);
    chk("st_we", {63'd0, dmem_we}, 64'd1);
    chk("st_wdata", dmem_wdata, 64'h55);
    step();
    nop();
    #2 chk("st_wb_rw", {63'd0, wb_reg_write}, 64'd0);
    step();

    $display("txn branch taken mispredict target=0x2000");
    branch = 1; zero = 1; prediction = 0; pc_plus_imm = 64'h2000; pc_value = 64'h1000;
    #2;
    chk("mp_flush", {63'd0, flush}, 64'd1);
    chk("mp_redirect", redirect_pc, 64'h2000);
    step();
    nop();
    #2;
    chk("mp_bp_update", {63'd0, bp_update}, 64'd1);
    chk("mp_bp_taken", {63'd0, bp_taken}, 64'd1);
    chk("mp_mcnt", 64'(mispredict_cnt), 64'd1);
    step();

    $display("txn branch not-taken mispredict pc=0x1000");
    branch = 1; zero = 0; prediction = 1; pc_value = 64'h1000; pc_plus_imm = 64'h3000;
    #2;
    chk("nt_bp_pulse", {63'd0, bp_update}, 64'd0);
    chk("nt_flush", {63'd0, flush}, 64'd1);
    chk("nt_redirect", redirect_pc, 64'h1004);
    step();
    nop();
    step();

    nbr = 2;
    for (int n = 0; n < 250; n++) begin
      nop();
      kind = $urandom_range(0, 3);
      alu_result = {$urandom, $urandom}; rd2 = {$urandom, $urandom};
      rd = 5'($urandom_range(0, 31));
      reg_write = 1'($urandom_range(0, 1)); memToReg = 1'($urandom_range(0, 1));
      pc_value = {$urandom, $urandom}; pc_plus_imm = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) pc_value = 64'hFFFF_FFFF_FFFF_FFFC + 64'($urandom_range(0, 3));
      zero = 1'($urandom_range(0, 1)); prediction = 1'($urandom_range(0, 1));
      case (kind)
        1: mem_read = 1;
        2: mem_write = 1;
        3: begin branch = 1; nbr++; end
        default: ;
      endcase
      w = (kind == 1 || kind == 2) ? $urandom_range(0, 4) : 0;
      $display("txn %0d kind=%0d waits=%0d", n, kind, w);
      for (int j = 0; j < w; j++) begin
        dmem_ready = 0; dmem_rdata = {$urandom, $urandom};
        step();
      end
      dmem_ready = (kind == 1 || kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      dmem_rdata = {$urandom, $urandom};
      step();
    end
    nop();
    #2 chk("branch_sat", 64'(branch_cnt), (nbr > SAT) ? 64'(SAT) : 64'(nbr));
    step();

    $display("txn load timeout addr=0x400");
    mem_read = 1; alu_result = 64'h400; reg_write = 1; dmem_ready = 0;
    for (int i = 0; i < TMO; i++) begin
      #2 chk("tmo_stall", {63'd0, stall}, 64'd1);
      step();
    end
    #2;
    chk("tmo_err", {63'd0, dmem_err}, 64'd1);
    chk("tmo_stall_after", {63'd0, stall}, 64'd0);
    chk("tmo_req_after", {63'd0, dmem_req}, 64'd0);
    step();
    rst_n = 0;
    model_reset();
    nop();
    step();
    rst_n = 1;

    $display("txn reset during wait addr=0x500");
    alu_result = 64'h77; reg_write = 1;
    step();
    nop();
    mem_read = 1; alu_result = 64'h500; reg_write = 1; dmem_ready = 0;
    step(); step();
    #2 chk("rw_stall_pre", {63'd0, stall}, 64'd1);
    rst_n = 0;
    model_reset();
    #1;
    chk("rw_stall", {63'd0, stall}, 64'd0);
    chk("rw_req", {63'd0, dmem_req}, 64'd0);
    chk("rw_wb_rw", {63'd0, wb_reg_write}, 64'd0);
    chk("rw_wb_alu", wb_alu_result, 64'd0);
    chk("rw_err", {63'd0, dmem_err}, 64'd0);
    chk("rw_bcnt", 64'(branch_cnt), 64'd0);
    step();
    nop();
    rst_n = 1;
    step();
    #2 chk("rw_idle_stall", {63'd0, stall}, 64'd0);
    step();

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
